// File: rtl/tmds_pkg.sv
// Shared TMDS receive-side constants: control tokens, HDMI TERC4 code table and
// the word-alignment state encoding.
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    // Index k holds the 10-bit code carrying nibble k.
    localparam logic [15:0][9:0] TERC4_CODE = {
        10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
        10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
        10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
        10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
    };

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one aligned TMDS word into token/ctrl, pixel byte and,
// when TMDS_WORD_DECODER_TERC4_EN is defined, the TERC4 nibble.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] w,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic       terc4_valid,
    output logic [3:0] terc4
);

    logic [7:0] q;
    logic [7:0] qx;

    always_comb begin
        is_token = 1'b1;
        ctrl     = 2'b00;
        case (w)
            TOKEN_C00: ctrl = 2'b00;
            TOKEN_C01: ctrl = 2'b01;
            TOKEN_C10: ctrl = 2'b10;
            TOKEN_C11: ctrl = 2'b11;
            default:   is_token = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign q    = w[9] ? ~w[7:0] : w[7:0];
    assign qx   = q ^ {q[6:0], 1'b0};
    assign data = w[8] ? {qx[7:1], q[0]} : {~qx[7:1], q[0]};

`ifdef TMDS_WORD_DECODER_TERC4_EN
    always_comb begin
        terc4_valid = 1'b0;
        terc4       = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (w == TERC4_CODE[k]) begin
                terc4_valid = 1'b1;
                terc4       = 4'(k);
            end
        end
    end
`else
    assign terc4_valid = 1'b0;
    assign terc4       = 4'd0;
`endif

endmodule

// File: rtl/tmds_word_decoder.sv
// TMDS receive channel: bit-slip word alignment on control-token runs and
// registered word decode. Optional TERC4 detection via TMDS_WORD_DECODER_TERC4_EN.
module tmds_word_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_WINDOW  = 1024,
    parameter int UNLOCK_TIMEOUT = 4096
) (
    input  logic       pixclk,
    input  logic       resetn,
    input  logic [9:0] tmds_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset,
    output logic [3:0] terc4,
    output logic       terc4_valid
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
    localparam int TMO_W = $clog2(UNLOCK_TIMEOUT + 1);

    logic [19:0]      hist_p0;
    logic [9:0]       w_p1;
    logic             dec_is_token;
    logic [1:0]       dec_ctrl;
    logic [7:0]       dec_data;
    logic             dec_terc4_valid;
    logic [3:0]       dec_terc4;

    align_state_t     state, state_next;
    logic [3:0]       offset_next;
    logic [RUN_W-1:0] run_cnt, run_next, run_inc;
    logic [WIN_W-1:0] win_cnt, win_next, win_inc;
    logic [TMO_W-1:0] tmo_cnt, tmo_next, tmo_inc;

    // Stage p0: two-word history so any of the ten bit offsets can be extracted.
    always_ff @(posedge pixclk) begin
        if (!resetn) hist_p0 <= '0;
        else         hist_p0 <= {tmds_in, hist_p0[19:10]};
    end

    // Stage p1: aligned word and its combinational decode.
    always_comb begin
        w_p1 = hist_p0[9:0];
        for (int k = 1; k < 10; k++) begin
            if (offset == 4'(k)) w_p1 = hist_p0[k +: 10];
        end
    end

    tmds_word_decode u_decode (
        .w           (w_p1),
        .is_token    (dec_is_token),
        .ctrl        (dec_ctrl),
        .data        (dec_data),
        .terc4_valid (dec_terc4_valid),
        .terc4       (dec_terc4)
    );

    assign run_inc = run_cnt + 1'b1;
    assign win_inc = win_cnt + 1'b1;
    assign tmo_inc = tmo_cnt + 1'b1;

    always_comb begin
        state_next  = state;
        offset_next = offset;
        run_next    = run_cnt;
        win_next    = win_cnt;
        tmo_next    = tmo_cnt;
        case (state)
            SEARCH: begin
                run_next = dec_is_token ? run_inc : '0;
                win_next = win_inc;
                // A completed run takes priority over a window expiring on the same word.
                if (dec_is_token && run_inc == RUN_W'(LOCK_COUNT)) begin
                    state_next = LOCKED;
                    run_next   = '0;
                    win_next   = '0;
                    tmo_next   = '0;
                end else if (win_inc == WIN_W'(SEARCH_WINDOW)) begin
                    offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    run_next    = '0;
                    win_next    = '0;
                end
            end
            LOCKED: begin
                tmo_next = dec_is_token ? '0 : tmo_inc;
                if (!dec_is_token && tmo_inc == TMO_W'(UNLOCK_TIMEOUT)) begin
                    state_next = SEARCH;
                    run_next   = '0;
                    win_next   = '0;
                    tmo_next   = '0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            state   <= SEARCH;
            offset  <= 4'd0;
            run_cnt <= '0;
            win_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            offset  <= offset_next;
            run_cnt <= run_next;
            win_cnt <= win_next;
            tmo_cnt <= tmo_next;
        end
    end

    // Stage p2: output registers, gated by the state this word leaves the FSM in,
    // so de and locked always agree.
    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            data        <= 8'd0;
            ctrl        <= 2'b00;
            de          <= 1'b0;
            terc4       <= 4'd0;
            terc4_valid <= 1'b0;
        end else begin
            terc4       <= dec_terc4;
            terc4_valid <= dec_terc4_valid;
            if (state_next == LOCKED && !dec_is_token) begin
                de   <= 1'b1;
                data <= dec_data;
            end else begin
                de   <= 1'b0;
                data <= 8'd0;
            end
            if (state_next == LOCKED && dec_is_token) ctrl <= dec_ctrl;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tmds_word_decoder.sv
// Scoreboard bench for tmds_word_decoder: expected outputs queued per driven word
// and compared two edges after capture; TERC4 expectations follow TMDS_WORD_DECODER_TERC4_EN.
module tb_tmds_word_decoder;

    localparam int LOCK_COUNT     = 8;
    localparam int SEARCH_WINDOW  = 32;
    localparam int UNLOCK_TIMEOUT = 64;
`ifdef TMDS_WORD_DECODER_TERC4_EN
    localparam bit TERC4_ON = 1'b1;
`else
    localparam bit TERC4_ON = 1'b0;
`endif

    logic       pixclk;
    logic       resetn;
    logic [9:0] tmds_in;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;
    logic [3:0] terc4;
    logic       terc4_valid;

    tmds_word_decoder #(
        .LOCK_COUNT     (LOCK_COUNT),
        .SEARCH_WINDOW  (SEARCH_WINDOW),
        .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
    ) dut (
        .pixclk      (pixclk),
        .resetn      (resetn),
        .tmds_in     (tmds_in),
        .data        (data),
        .ctrl        (ctrl),
        .de          (de),
        .locked      (locked),
        .offset      (offset),
        .terc4       (terc4),
        .terc4_valid (terc4_valid)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    typedef struct {
        int         due;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic       lck;
        logic [4:0] t4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   tx_cnt   = 0;
    bit   mdl_locked;
    int   mdl_run;
    int   idle_k;
    logic [1:0] cur_ctrl;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Transmitter-side DVI 8b/10b encoder with running disparity.
    function automatic logic [9:0] tx_encode(input logic [7:0] d);
        logic [8:0] qm;
        int n1d, n1q, n0q;
        logic [9:0] qo;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (tx_cnt == 0 || n1q == n0q) begin
            qo = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            tx_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((tx_cnt > 0 && n1q > n0q) || (tx_cnt < 0 && n0q > n1q)) begin
            qo = {1'b1, qm[8], ~qm[7:0]};
            tx_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            qo = {1'b0, qm[8], qm[7:0]};
            tx_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
        end
        return qo;
    endfunction

    function automatic logic [4:0] terc4_ref(input logic [9:0] w);
        logic [4:0] r;
        case (w)
            10'b1010011100: r = 5'h10;  10'b1001100011: r = 5'h11;
            10'b1011100100: r = 5'h12;  10'b1011100010: r = 5'h13;
            10'b0101110001: r = 5'h14;  10'b0100011110: r = 5'h15;
            10'b0110001110: r = 5'h16;  10'b0100111100: r = 5'h17;
            10'b1011001100: r = 5'h18;  10'b0100111001: r = 5'h19;
            10'b0110011100: r = 5'h1A;  10'b1011000110: r = 5'h1B;
            10'b1010001110: r = 5'h1C;  10'b1001110001: r = 5'h1D;
            10'b0101100011: r = 5'h1E;  10'b1011000011: r = 5'h1F;
            default:        r = 5'h00;
        endcase
        return TERC4_ON ? r : 5'h00;
    endfunction

    // Outputs for the word captured at edge N are due just after edge N+2.
    always @(posedge pixclk) begin
        exp_t e;
        cyc++;
        #1;
        if (!resetn) sb.delete();
        else begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check_eq("sb_de",     32'(de),     32'(e.de));
                check_eq("sb_ctrl",   32'(ctrl),   32'(e.ctrl));
                check_eq("sb_data",   32'(data),   32'(e.data));
                check_eq("sb_locked", 32'(locked), 32'(e.lck));
                check_eq("sb_terc4",  32'({terc4_valid, terc4}), 32'(e.t4));
            end
        end
    end

    task automatic step(input logic [9:0] w, input exp_t e);
        @(negedge pixclk);
        tmds_in = w;
        e.due   = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic send_token(input logic [9:0] w, input logic [1:0] c);
        exp_t e;
        if (!mdl_locked) begin
            mdl_run++;
            if (mdl_run == LOCK_COUNT) begin
                mdl_locked = 1'b1;
                idle_k     = 0;
            end
        end else idle_k = 0;
        if (mdl_locked) cur_ctrl = c;
        e.de = 1'b0; e.data = 8'd0; e.ctrl = cur_ctrl; e.lck = mdl_locked; e.t4 = terc4_ref(w);
        step(w, e);
    endtask

    task automatic send_word(input logic [9:0] w, input logic [7:0] b);
        exp_t e;
        if (mdl_locked) begin
            idle_k++;
            if (idle_k == UNLOCK_TIMEOUT) mdl_locked = 1'b0;
        end else mdl_run = 0;
        e.de = mdl_locked; e.data = mdl_locked ? b : 8'd0; e.ctrl = cur_ctrl;
        e.lck = mdl_locked; e.t4 = terc4_ref(w);
        step(w, e);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_word(tx_encode(b), b);
    endtask

    task automatic do_reset(input logic [9:0] idle);
        repeat (3) begin
            @(negedge pixclk);
            resetn  = 1'b0;
            tmds_in = 10'($urandom);
        end
        @(posedge pixclk);
        #1;
        check_eq("rst_data",   32'(data),   32'h0);
        check_eq("rst_ctrl",   32'(ctrl),   32'h0);
        check_eq("rst_de",     32'(de),     32'h0);
        check_eq("rst_locked", 32'(locked), 32'h0);
        check_eq("rst_offset", 32'(offset), 32'h0);
        check_eq("rst_terc4",  32'({terc4_valid, terc4}), 32'h0);
        @(negedge pixclk);
        resetn     = 1'b1;
        tmds_in    = idle;
        mdl_locked = 1'b0;
        mdl_run    = 0;
        idle_k     = 0;
        cur_ctrl   = 2'b00;
        tx_cnt     = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] rot;
        int c, slips, t_lock;
        int t_slip[3];
        logic [3:0] prev_off;

        resetn  = 1'b0;
        tmds_in = 10'd0;

        // Aligned lock, data decode, TERC4 words, then unlock by timeout.
        do_reset(10'd0);
        repeat (LOCK_COUNT) send_token(10'h354, 2'b00);
        send_token(10'h0AB, 2'b01);
        send_data(8'h00);
        send_data(8'hFF);
        send_data(8'h10);
        send_data(8'hA5);
        send_token(10'h2AB, 2'b11);
        send_data(8'h3C);
        send_word(10'b1010011100, 8'h5B);
        send_word(10'b1011000011, 8'hBA);
        while (mdl_locked) send_data(8'($urandom));
        repeat (5) send_data(8'($urandom));
        repeat (3) @(posedge pixclk);
        #1;
        check_eq("unlock_offset", 32'(offset), 32'd0);
        check_eq("unlock_locked", 32'(locked), 32'd0);

        // Token stream rotated so it only aligns at offset 3.
        rot = 10'b1010100110;
        do_reset(rot);
        c = 0; slips = 0; t_lock = -1; prev_off = 4'd0;
        t_slip = '{-1, -1, -1};
        while (t_lock < 0 && c < 4 * SEARCH_WINDOW + LOCK_COUNT + 20) begin
            @(posedge pixclk);
            #1;
            c++;
            if (offset != prev_off) begin
                if (slips < 3) t_slip[slips] = c;
                slips++;
                prev_off = offset;
            end
            if (locked) t_lock = c;
        end
        check_eq("slip_count", 32'(slips), 32'd3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("slip%0d_cycle", i), 32'(t_slip[i]), 32'((i + 1) * SEARCH_WINDOW));
        check_eq("slip_lock_cycle", 32'(t_lock), 32'(3 * SEARCH_WINDOW + LOCK_COUNT));
        repeat (SEARCH_WINDOW + 5) @(posedge pixclk);
        #1;
        check_eq("slip_hold_offset", 32'(offset), 32'd3);
        check_eq("slip_hold_locked", 32'(locked), 32'd1);
        check_eq("slip_hold_de",     32'(de),     32'd0);

        // Reset while locked.
        do_reset(10'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
